// File: rtl/snake_datapath.sv
// Snake movement datapath: head register, body-position RAM, address counter,
// prev/curr shift registers and plot output. Define SNAKE_WRAP_EN for wrap-around edges.
module snake_datapath #(
  parameter int unsigned DEPTH    = 1024,
  parameter int unsigned ADDR_W   = 10,
  parameter int unsigned X_W      = 8,
  parameter int unsigned Y_W      = 7,
  parameter int unsigned SCREEN_W = 160,
  parameter int unsigned SCREEN_H = 120,
  parameter int unsigned STEP     = 2,
  parameter int unsigned HEAD_X0  = 80,
  parameter int unsigned HEAD_Y0  = 60
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [1:0]     direction,
  input  logic           ld_head,
  input  logic           ld_q_def,
  input  logic           inc_address,
  input  logic           rst_address,
  input  logic           update_head,
  input  logic           ld_head_into_prev,
  input  logic           ld_q_into_curr,
  input  logic           ld_prev_into_q,
  input  logic           ld_curr_into_prev,
  input  logic           draw_q,
  input  logic           draw_curr,
  input  logic [1:0]     cnt_status,
  input  logic [2:0]     colour_in,
  output logic [X_W-1:0] x_out,
  output logic [Y_W-1:0] y_out,
  output logic [2:0]     colour_out,
  output logic           plot,
  output logic [X_W-1:0] head_x,
  output logic [Y_W-1:0] head_y,
  output logic           hit_wall
);

  typedef struct packed {
    logic [X_W-1:0] x;
    logic [Y_W-1:0] y;
  } cell_t;

  cell_t             mem [DEPTH];
  cell_t             q_data;
  cell_t             prev;
  cell_t             curr;
  cell_t             wr_data_c;
  logic              wr_en_c;
  logic [ADDR_W-1:0] addr;
  logic [1:0]        last_dir;
  logic [1:0]        dir_eff_c;
  logic [X_W-1:0]    next_x_c;
  logic [Y_W-1:0]    next_y_c;
`ifndef SNAKE_WRAP_EN
  logic              edge_c;
`endif

  // RAM write source: default body layout beats the shifted-in prev cell
  always_comb begin
    wr_en_c   = 1'b0;
    wr_data_c = prev;
    if (ld_q_def) begin
      wr_en_c     = 1'b1;
      wr_data_c.x = X_W'(HEAD_X0 - STEP * 32'(addr));
      wr_data_c.y = Y_W'(HEAD_Y0);
    end else if (ld_prev_into_q) begin
      wr_en_c = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en_c && !rst) mem[addr] <= wr_data_c;
  end

  // Next head position; a reversal request keeps the previous heading
  always_comb begin
    dir_eff_c = (direction == ~last_dir) ? last_dir : direction;
    next_x_c  = head_x;
    next_y_c  = head_y;
`ifndef SNAKE_WRAP_EN
    edge_c    = 1'b0;
`endif
    case (dir_eff_c)
      2'b00: begin
        if (32'(head_x) + STEP > SCREEN_W - STEP) begin
`ifdef SNAKE_WRAP_EN
          next_x_c = '0;
`else
          next_x_c = X_W'(SCREEN_W - STEP);
          edge_c   = 1'b1;
`endif
        end else begin
          next_x_c = head_x + X_W'(STEP);
        end
      end
      2'b01: begin
        if (32'(head_y) < STEP) begin
`ifdef SNAKE_WRAP_EN
          next_y_c = Y_W'(SCREEN_H - STEP);
`else
          next_y_c = '0;
          edge_c   = 1'b1;
`endif
        end else begin
          next_y_c = head_y - Y_W'(STEP);
        end
      end
      2'b10: begin
        if (32'(head_y) + STEP > SCREEN_H - STEP) begin
`ifdef SNAKE_WRAP_EN
          next_y_c = '0;
`else
          next_y_c = Y_W'(SCREEN_H - STEP);
          edge_c   = 1'b1;
`endif
        end else begin
          next_y_c = head_y + Y_W'(STEP);
        end
      end
      default: begin
        if (32'(head_x) < STEP) begin
`ifdef SNAKE_WRAP_EN
          next_x_c = X_W'(SCREEN_W - STEP);
`else
          next_x_c = '0;
          edge_c   = 1'b1;
`endif
        end else begin
          next_x_c = head_x - X_W'(STEP);
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_x     <= X_W'(HEAD_X0);
      head_y     <= Y_W'(HEAD_Y0);
      last_dir   <= 2'b00;
      addr       <= '0;
      prev       <= '0;
      curr       <= '0;
      q_data     <= '0;
      x_out      <= '0;
      y_out      <= '0;
      colour_out <= '0;
      plot       <= 1'b0;
    end else begin
      q_data <= mem[addr];
      if (ld_head) begin
        head_x   <= X_W'(HEAD_X0);
        head_y   <= Y_W'(HEAD_Y0);
        last_dir <= 2'b00;
      end else if (update_head) begin
        head_x   <= next_x_c;
        head_y   <= next_y_c;
        last_dir <= dir_eff_c;
      end
      if (rst_address) begin
        addr <= '0;
      end else if (inc_address) begin
        addr <= (addr == ADDR_W'(DEPTH - 1)) ? '0 : addr + ADDR_W'(1);
      end
      if (ld_curr_into_prev) begin
        prev <= curr;
      end else if (ld_head_into_prev) begin
        prev <= cell_t'{x: head_x, y: head_y};
      end
      if (ld_q_into_curr) curr <= q_data;
      plot <= draw_q | draw_curr;
      if (draw_q) begin
        x_out      <= q_data.x + X_W'(cnt_status[0]);
        y_out      <= q_data.y + Y_W'(cnt_status[1]);
        colour_out <= colour_in;
      end else if (draw_curr) begin
        x_out      <= curr.x + X_W'(cnt_status[0]);
        y_out      <= curr.y + Y_W'(cnt_status[1]);
        colour_out <= colour_in;
      end
    end
  end

`ifdef SNAKE_WRAP_EN
  assign hit_wall = 1'b0;
`else
  // Sticky until reset or a fresh head load
  always_ff @(posedge clk) begin
    if (rst || ld_head) begin
      hit_wall <= 1'b0;
    end else if (update_head && edge_c) begin
      hit_wall <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_snake_datapath.sv
// Self-checking bench for snake_datapath: directed scenarios plus random strobes
// checked every cycle against a behavioural model of the datapath.
module tb_snake_datapath;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] direction = '0;
  logic       ld_head = 0, ld_q_def = 0, inc_address = 0, rst_address = 0;
  logic       update_head = 0, ld_head_into_prev = 0, ld_q_into_curr = 0;
  logic       ld_prev_into_q = 0, ld_curr_into_prev = 0, draw_q = 0, draw_curr = 0;
  logic [1:0] cnt_status = '0;
  logic [2:0] colour_in = '0;
  logic [7:0] x_out, head_x;
  logic [6:0] y_out, head_y;
  logic [2:0] colour_out;
  logic       plot, hit_wall;

  int n_vec = 0;
  int n_err = 0;
  bit chk = 0;

  snake_datapath dut (
    .clk(clk), .rst(rst), .direction(direction), .ld_head(ld_head), .ld_q_def(ld_q_def),
    .inc_address(inc_address), .rst_address(rst_address), .update_head(update_head),
    .ld_head_into_prev(ld_head_into_prev), .ld_q_into_curr(ld_q_into_curr),
    .ld_prev_into_q(ld_prev_into_q), .ld_curr_into_prev(ld_curr_into_prev),
    .draw_q(draw_q), .draw_curr(draw_curr), .cnt_status(cnt_status), .colour_in(colour_in),
    .x_out(x_out), .y_out(y_out), .colour_out(colour_out), .plot(plot),
    .head_x(head_x), .head_y(head_y), .hit_wall(hit_wall)
  );

  always #5 clk = ~clk;

  // Behavioural model: positions as plain integers, RAM as arrays
  int hx, hy, ldir, hit, am, qx, qy, px, py, cx, cy, xo, yo, co, pl;
  int mx [1024];
  int my [1024];

  always @(posedge clk) begin : model
    int oqx, oqy, opx, opy, ocx, ocy, ohx, ohy, eff, nx, ny;
    if (rst) begin
      hx = 80; hy = 60; ldir = 0; hit = 0; am = 0;
      qx = 0; qy = 0; px = 0; py = 0; cx = 0; cy = 0;
      xo = 0; yo = 0; co = 0; pl = 0;
    end else begin
      oqx = qx; oqy = qy; opx = px; opy = py; ocx = cx; ocy = cy; ohx = hx; ohy = hy;
      qx = mx[am]; qy = my[am];
      if (ld_q_def) begin
        mx[am] = (80 - 2 * am) & 255; my[am] = 60;
      end else if (ld_prev_into_q) begin
        mx[am] = opx; my[am] = opy;
      end
      pl = (draw_q || draw_curr) ? 1 : 0;
      if (draw_q) begin
        xo = (oqx + cnt_status[0]) & 255; yo = (oqy + cnt_status[1]) & 127; co = colour_in;
      end else if (draw_curr) begin
        xo = (ocx + cnt_status[0]) & 255; yo = (ocy + cnt_status[1]) & 127; co = colour_in;
      end
      if (ld_q_into_curr) begin cx = oqx; cy = oqy; end
      if (ld_curr_into_prev) begin px = ocx; py = ocy; end
      else if (ld_head_into_prev) begin px = ohx; py = ohy; end
      if (ld_head) begin
        hx = 80; hy = 60; ldir = 0; hit = 0;
      end else if (update_head) begin
        eff = (int'(direction) == 3 - ldir) ? ldir : int'(direction);
        nx = hx + ((eff == 0) ? 2 : (eff == 3) ? -2 : 0);
        ny = hy + ((eff == 2) ? 2 : (eff == 1) ? -2 : 0);
`ifdef SNAKE_WRAP_EN
        if (nx < 0) nx = 158; else if (nx > 158) nx = 0;
        if (ny < 0) ny = 118; else if (ny > 118) ny = 0;
`else
        if (nx < 0 || nx > 158 || ny < 0 || ny > 118) hit = 1;
        if (nx < 0) nx = 0; else if (nx > 158) nx = 158;
        if (ny < 0) ny = 0; else if (ny > 118) ny = 118;
`endif
        hx = nx; hy = ny; ldir = eff;
      end
      if (rst_address) am = 0; else if (inc_address) am = (am + 1) % 1024;
    end
  end

  // Per-cycle comparison of every output against the model
  always @(negedge clk) begin
    if (chk) begin
      n_vec++;
      if (int'(head_x) != hx || int'(head_y) != hy || int'(hit_wall) != hit ||
          int'(plot) != pl || int'(x_out) != xo || int'(y_out) != yo || int'(colour_out) != co) begin
        n_err++;
        if (n_err < 20)
          $display("FAIL cycle_model t=%0t: got head=(%0d,%0d) hit=%0d plot=%0d xy=(%0d,%0d) col=%0d, required head=(%0d,%0d) hit=%0d plot=%0d xy=(%0d,%0d) col=%0d",
                   $time, head_x, head_y, hit_wall, plot, x_out, y_out, colour_out,
                   hx, hy, hit, pl, xo, yo, co);
      end
    end
  end

  task automatic lit(input string nm, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d required %0d", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic clr();
    ld_head = 0; ld_q_def = 0; inc_address = 0; rst_address = 0; update_head = 0;
    ld_head_into_prev = 0; ld_q_into_curr = 0; ld_prev_into_q = 0; ld_curr_into_prev = 0;
    draw_q = 0; draw_curr = 0; cnt_status = 0; rst = 0;
  endtask

  initial begin
    // reset state
    tick();
    lit("rst_head_x", int'(head_x), 80);
    lit("rst_head_y", int'(head_y), 60);
    lit("rst_plot", int'(plot), 0);
    lit("rst_hit", int'(hit_wall), 0);
    chk = 1;
    clr();

    // fill whole RAM with default layout; address wraps back to 0
    ld_q_def = 1; inc_address = 1;
    repeat (1024) tick();
    clr(); tick();
    draw_q = 1; colour_in = 3'd5; tick();
    lit("addr_wrap_x", int'(x_out), 80);
    lit("draw_colour", int'(colour_out), 5);
    clr(); tick();
    lit("plot_drop", int'(plot), 0);

    // default body + sub-pixel plotting
    rst_address = 1; tick(); clr();
    ld_q_def = 1; inc_address = 1; repeat (4) tick(); clr();
    rst_address = 1; tick(); clr();
    inc_address = 1; repeat (2) tick(); clr();
    tick();
    for (int c = 0; c < 4; c++) begin
      draw_q = 1; cnt_status = 2'(c); tick();
      lit("subpix_x", int'(x_out), 76 + (c & 1));
      lit("subpix_y", int'(y_out), 60 + (c >> 1));
    end
    clr();

    // reversal ignored
    ld_head = 1; tick(); clr();
    update_head = 1; direction = 2'b01; tick();
    lit("up_y", int'(head_y), 58);
    direction = 2'b10; tick();
    lit("rev_x", int'(head_x), 80);
    lit("rev_y", int'(head_y), 56);
    clr();

    // shift a length-3 body behind the moved head
    ld_head = 1; tick(); clr();
    update_head = 1; direction = 2'b00; tick(); clr();
    lit("right_x", int'(head_x), 82);
    rst_address = 1; tick(); clr();
    ld_head_into_prev = 1; tick(); clr();
    for (int i = 0; i < 3; i++) begin
      ld_q_into_curr = 1; tick(); clr();
      ld_prev_into_q = 1; ld_curr_into_prev = 1; inc_address = 1; tick(); clr();
      tick();
    end
    draw_curr = 1; tick(); clr();
    lit("curr_x", int'(x_out), 76);
    lit("curr_y", int'(y_out), 60);
    rst_address = 1; tick(); clr(); tick();
    draw_q = 1; tick(); clr();
    lit("mem0_x", int'(x_out), 82);

    // left wall
    ld_head = 1; tick(); clr();
    update_head = 1; direction = 2'b01; tick();
    direction = 2'b11; repeat (40) tick();
    direction = 2'b10; tick();
    lit("edge_x", int'(head_x), 0);
    lit("edge_y", int'(head_y), 60);
    direction = 2'b11; tick(); clr();
`ifdef SNAKE_WRAP_EN
    lit("wall_x", int'(head_x), 158);
    lit("wall_hit", int'(hit_wall), 0);
`else
    lit("wall_x", int'(head_x), 0);
    lit("wall_hit", int'(hit_wall), 1);
`endif
    ld_head = 1; tick(); clr();
    lit("hit_clear", int'(hit_wall), 0);

    // rst_address beats inc_address
    inc_address = 1; repeat (3) tick();
    rst_address = 1; tick(); clr(); tick();
    draw_q = 1; tick(); clr();
    lit("inc_rst_addr", int'(x_out), 82);

    // reset in the middle of a shift
    update_head = 1; direction = 2'b00; tick(); clr();
    ld_head_into_prev = 1; inc_address = 1; ld_q_into_curr = 1; draw_q = 1; rst = 1; tick(); clr();
    lit("midrst_head_x", int'(head_x), 80);
    lit("midrst_plot", int'(plot), 0);
    lit("midrst_x_out", int'(x_out), 0);
    draw_curr = 1; tick(); clr();
    lit("midrst_curr", int'(x_out), 0);

    // random strobes
    repeat (3000) begin
      rst = ($urandom_range(0, 199) == 0);
      direction = 2'($urandom_range(0, 3));
      ld_head = ($urandom_range(0, 39) == 0);
      ld_q_def = ($urandom_range(0, 7) == 0);
      inc_address = ($urandom_range(0, 2) == 0);
      rst_address = ($urandom_range(0, 15) == 0);
      update_head = ($urandom_range(0, 2) == 0);
      ld_q_into_curr = ($urandom_range(0, 3) == 0);
      ld_prev_into_q = ($urandom_range(0, 3) == 0);
      ld_curr_into_prev = ($urandom_range(0, 3) == 0);
      ld_head_into_prev = !ld_curr_into_prev && ($urandom_range(0, 3) == 0);
      draw_q = ($urandom_range(0, 2) == 0);
      draw_curr = ($urandom_range(0, 2) == 0);
      cnt_status = 2'($urandom_range(0, 3));
      colour_in = 3'($urandom_range(0, 7));
      tick();
    end
    clr(); tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
